reg_dump_tx: RTL and testbench
==============================

Name: reg_dump_tx

Overview:
- Reader side of the register bank: when triggered, walks every register through one bank read port and streams the contents out as bytes over a valid/ready channel.
- Sits beside the register bank in the core top level, sharing a read port with the debug path.
- Feeds a byte sink such as a serial transmitter or display driver.

Parameters:
NREG, 16, number of registers dumped (addresses 0..NREG-1)
AW, 4, register address width; NREG <= 2**AW
DW, 32, register data width; multiple of 8

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a dump; ignored while busy
rd_addr  output  AW  read address to register bank
rd_data  input  DW  bank read data, combinational from rd_addr
tx_data  output  8  byte presented to sink
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts byte when tx_valid && tx_ready at clock edge
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse after final byte accepted

Behaviour:
- Reset (async, active-high) values: rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE, internal counters=0. Asserting rst mid-dump aborts immediately; no further bytes are sent after release until a new start.
- States: IDLE, LATCH, HDR, DATA, DONE.
- IDLE: on start=1, set rd_addr=0, busy=1, and go to LATCH.
- LATCH (1 cycle): capture rd_data into shift register sh[DW-1:0]. Load tx_data={4'hA, rd_addr[3:0]} (for AW>4 use the low 4 bits), set tx_valid=1, byte_cnt=0, and go to HDR.
- HDR: hold tx_data/tx_valid until handshake. On tx_valid&&tx_ready, load tx_data=sh[DW-1:DW-8] (MSB byte first) and go to DATA.
- DATA: on each handshake, byte_cnt++ and shift sh left by 8.
  - If bytes remain, load the next MSB byte.
  - After byte DW/8-1 is accepted, drop tx_valid in the same edge.
  - If rd_addr==NREG-1, go to DONE; otherwise rd_addr++ and go to LATCH.
- DONE (1 cycle): done=1, busy=0 on the next edge; return to IDLE.
- Per-register frame: 1 header + DW/8 data bytes (5 bytes for defaults). A full dump is NREG*5 = 80 bytes.
- Minimum latency with tx_ready held high:
  - start edge -> first tx_valid: 2 cycles (IDLE->LATCH->HDR visible).
  - Each register costs 1 LATCH cycle + 5 transfer cycles.
  - Full dump = 96 cycles + 1 DONE cycle.
- Handshake rules:
  - tx_data stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake, except on reset.
  - tx_valid is low in IDLE, LATCH and DONE.
  - Backpressure of any length is tolerated.
- Snapshot semantics: register value is captured in LATCH. Writes to that register during its frame do not affect the bytes sent. Writes to later registers before their LATCH are observed.
- start during busy (including during DONE): ignored, not queued. start in the same cycle as rst: reset wins.
- rd_addr is held constant from LATCH through the end of that register's frame.
- Wrap: rd_addr never exceeds NREG-1; no wrap to 0 inside a dump.

Test Plan:
- Reset then idle: rst pulse, no start -> tx_valid=0, busy=0, done=0, rd_addr=0 for 20 cycles.
- Full dump, tx_ready=1: bank reg k = 32'h1000_0000+k, start at cycle 0 -> first byte 8'hA0 at cycle 2. Byte stream A0,10,00,00,00,A1,10,00,00,01 ... AF,10,00,00,0F (80 bytes, no gaps within a frame). done pulses exactly once at cycle 97; busy falls the same cycle.
- Backpressure: tx_ready random 30% duty, reg3=32'hDEADBEEF -> frame A3,DE,AD,BE,EF. tx_data unchanged across every stalled cycle; byte count 80 total.
- Snapshot: during reg 5 HDR, write reg5=32'h0 from 32'h55AA55AA, and write reg6=32'h12345678 -> frame 5 sends 55,AA,55,AA; frame 6 sends 12,34,56,78.
- Start while busy: second start pulse at byte 40 -> exactly 80 bytes and one done pulse.
- Reset mid-dump: rst asserted during reg 7 DATA byte 2 -> tx_valid=0 and busy=0 asynchronously. After release, a new start restarts from header A0.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Register bank dump transmitter: walks all NREG registers through a single
// combinational read port and streams each as a header byte {4'hA, addr}
// followed by DW/8 data bytes (MSB first) over a valid/ready byte channel.
module reg_dump_tx #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam int NB = DW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, HDR, DATA, DONE} state_t;

  state_t        state;
  logic [DW-1:0] sh;
  logic [CW-1:0] byte_cnt;

  logic [DW-1:0] sh_next;
  logic          last_byte;
  logic          last_reg;

  // Next shift-register contents and end-of-frame / end-of-dump flags
  always_comb begin
    sh_next   = sh << 8;
    last_byte = (byte_cnt == CW'(NB - 1));
    last_reg  = (rd_addr == AW'(NREG - 1));
  end

  // Dump sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      byte_cnt <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= LATCH;
          end
        end
        LATCH: begin
          sh       <= rd_data;
          tx_data  <= {4'hA, 4'(rd_addr)};
          tx_valid <= 1'b1;
          byte_cnt <= '0;
          state    <= HDR;
        end
        HDR: begin
          if (tx_ready) begin
            tx_data <= sh[DW-1 -: 8];
            state   <= DATA;
          end
        end
        DATA: begin
          if (tx_ready) begin
            sh <= sh_next;
            if (last_byte) begin
              tx_valid <= 1'b0;
              byte_cnt <= '0;
              if (last_reg) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                rd_addr <= rd_addr + AW'(1);
                state   <= LATCH;
              end
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              tx_data  <= sh_next[DW-1 -: 8];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx: cycle-accurate timing table for a full
// dump plus a byte scoreboard fed from a bank model, with backpressure,
// snapshot, start-while-busy and mid-dump reset sequences.
module tb_reg_dump_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tx_ready = 1'b1;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] bank [16];
  logic [31:0] snap [16];
  logic [7:0]  expq [$];

  int passes = 0;
  int total  = 0;
  int nbytes = 0;
  int ndone  = 0;
  int bp_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  typedef struct {
    int         cyc;
    logic       v;
    logic       b;
    logic       d;
    logic [7:0] data;
    logic [3:0] addr;
    bit         cd;
    bit         ca;
  } vec_t;

  vec_t tbl [12];

  reg_dump_tx #(.NREG(16), .AW(4), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  assign rd_data = bank[rd_addr];

  always #5 clk = ~clk;

  // Sink readiness: always ready, or ~30% random duty
  always @(posedge clk) begin
    #1;
    tx_ready = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Byte monitor: scoreboard pop on handshake, stall stability, done count
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {31'b0, tx_valid}, 32'd1);
        chk("stall_data_hold", {24'b0, tx_data}, {24'b0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        nbytes++;
        if (expq.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte: got %h expected no byte", tx_data);
        end else begin
          chk($sformatf("byte%0d", nbytes - 1), {24'b0, tx_data}, {24'b0, expq.pop_front()});
        end
      end
      if (done) ndone++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic init_bank();
    for (int k = 0; k < 16; k++) begin
      bank[k] = 32'h1000_0000 + k;
      snap[k] = 32'h1000_0000 + k;
    end
  endtask

  task automatic push_dump();
    for (int k = 0; k < 16; k++) begin
      expq.push_back(8'hA0 | 8'(k));
      for (int b = 3; b >= 0; b--) expq.push_back(snap[k][8*b +: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (ndone == 0 && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    if (ndone == 0) begin
      total++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", lim);
    end
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_sb_empty"}, expq.size(), 32'd0);
    chk({tag, "_byte_count"}, nbytes, 32'd80);
    chk({tag, "_done_count"}, ndone, 32'd1);
  endtask

  initial begin
    // Timing table for a full dump with tx_ready high (cycle 0 = start edge)
    tbl[0]  = '{1,  1'b0, 1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 1'b1};
    tbl[1]  = '{2,  1'b1, 1'b1, 1'b0, 8'hA0, 4'd0,  1'b1, 1'b1};
    tbl[2]  = '{3,  1'b1, 1'b1, 1'b0, 8'h10, 4'd0,  1'b1, 1'b1};
    tbl[3]  = '{6,  1'b1, 1'b1, 1'b0, 8'h00, 4'd0,  1'b1, 1'b1};
    tbl[4]  = '{7,  1'b0, 1'b1, 1'b0, 8'h00, 4'd1,  1'b0, 1'b1};
    tbl[5]  = '{8,  1'b1, 1'b1, 1'b0, 8'hA1, 4'd1,  1'b1, 1'b1};
    tbl[6]  = '{12, 1'b1, 1'b1, 1'b0, 8'h01, 4'd1,  1'b1, 1'b1};
    tbl[7]  = '{91, 1'b0, 1'b1, 1'b0, 8'h00, 4'd15, 1'b0, 1'b1};
    tbl[8]  = '{92, 1'b1, 1'b1, 1'b0, 8'hAF, 4'd15, 1'b1, 1'b1};
    tbl[9]  = '{96, 1'b1, 1'b1, 1'b0, 8'h0F, 4'd15, 1'b1, 1'b1};
    tbl[10] = '{97, 1'b0, 1'b0, 1'b1, 8'h00, 4'd15, 1'b0, 1'b1};
    tbl[11] = '{98, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0};

    init_bank();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", {31'b0, tx_valid}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_addr", {28'b0, rd_addr}, 32'd0);
    end

    // Full dump, timing table
    init_bank();
    push_dump();
    nbytes = 0; ndone = 0;
    pulse_start();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      for (int e = 0; e < 12; e++) begin
        if (tbl[e].cyc == c) begin
          chk($sformatf("c%0d_valid", c), {31'b0, tx_valid}, {31'b0, tbl[e].v});
          chk($sformatf("c%0d_busy", c), {31'b0, busy}, {31'b0, tbl[e].b});
          chk($sformatf("c%0d_done", c), {31'b0, done}, {31'b0, tbl[e].d});
          if (tbl[e].cd) chk($sformatf("c%0d_data", c), {24'b0, tx_data}, {24'b0, tbl[e].data});
          if (tbl[e].ca) chk($sformatf("c%0d_addr", c), {28'b0, rd_addr}, {28'b0, tbl[e].addr});
        end
      end
    end
    end_checks("full");

    // Backpressure with random ready
    init_bank();
    bank[3] = 32'hDEADBEEF;
    snap[3] = 32'hDEADBEEF;
    push_dump();
    nbytes = 0; ndone = 0;
    bp_mode = 1;
    pulse_start();
    wait_done(3000);
    bp_mode = 0;
    repeat (3) @(negedge clk);
    end_checks("bp");

    // Snapshot: register 5 captured before overwrite, register 6 written before its latch
    init_bank();
    bank[5] = 32'h55AA55AA;
    snap[5] = 32'h55AA55AA;
    snap[6] = 32'h12345678;
    push_dump();
    nbytes = 0; ndone = 0;
    pulse_start();
    begin
      int n = 0;
      while (!(tx_valid && rd_addr == 4'd5 && tx_data == 8'hA5) && n < 500) begin
        @(negedge clk); #1;
        n++;
      end
      chk("snap_hdr5_seen", {31'b0, tx_valid && rd_addr == 4'd5 && tx_data == 8'hA5}, 32'd1);
    end
    bank[5] = 32'h0;
    bank[6] = 32'h12345678;
    wait_done(500);
    repeat (3) @(negedge clk);
    end_checks("snap");

    // Start while busy and during DONE is ignored
    init_bank();
    push_dump();
    nbytes = 0; ndone = 0;
    pulse_start();
    begin
      int n = 0;
      while (nbytes < 40 && n < 500) begin
        @(negedge clk); #1;
        n++;
      end
    end
    pulse_start();
    wait_done(500);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rebusy_busy", {31'b0, busy}, 32'd0);
    chk("rebusy_valid", {31'b0, tx_valid}, 32'd0);
    end_checks("rebusy");

    // Reset mid-dump during register 7 data, then a clean restart
    init_bank();
    push_dump();
    nbytes = 0; ndone = 0;
    pulse_start();
    begin
      int n = 0;
      while (!(nbytes == 38 && tx_valid) && n < 500) begin
        @(negedge clk); #1;
        n++;
      end
      chk("rst_point_addr", {28'b0, rd_addr}, 32'd7);
    end
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_async_busy", {31'b0, busy}, 32'd0);
    chk("rst_async_addr", {28'b0, rd_addr}, 32'd0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nbytes = 0; ndone = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_bytes", nbytes, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    push_dump();
    pulse_start();
    wait_done(500);
    repeat (3) @(negedge clk);
    end_checks("restart");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
